mem_stage_pipe: RTL
===================

MEM_STAGE_PIPE -- requirements
Module: mem_stage_pipe

Interface
REQ-001 SHALL have parameter DATA_W, default 32: data and address width; legal values 32 only in this generation, checked at elaboration.
REQ-002 SHALL have parameter DEPTH, default 256: data memory depth in DATA_W words; power of two, 16..4096.
REQ-003 SHALL have parameter WAIT_CYC, default 2: memory wait states per access; legal range 0..7.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port wb_ctl_in, input, 2 bits: WB control from EX/MEM.
REQ-007 SHALL have ports branch and branch_ne, input, 1 bit each: branch-on-equal and branch-on-not-equal.
REQ-008 SHALL have ports memread and memwrite, input, 1 bit each: load and store request.
REQ-009 SHALL have port mem_size, input, 2 bits: 00 byte, 01 half, 10 word; 11 treated as word.
REQ-010 SHALL have port mem_unsigned, input, 1 bit: load zero-extends when 1, sign-extends when 0.
REQ-011 SHALL have ports npc_in, alu_result and wdata, input, DATA_W bits each: branch target, address, store data.
REQ-012 SHALL have port zero, input, 1 bit, and write_reg_in, input, 5 bits.
REQ-013 SHALL have outputs PCSrc (1), branch_addr (DATA_W), stall (1) and misalign (1).
REQ-014 SHALL have registered outputs mem_control_wb (2), mem_Read_data (DATA_W), mem_ALU_result (DATA_W) and mem_Write_reg (5).

Function
REQ-015 PCSrc SHALL be combinational: (branch & zero) | (branch_ne & ~zero); branch_addr SHALL equal npc_in.
REQ-016 Word index SHALL be alu_result[log2(DEPTH)+1:2], wrapping modulo DEPTH; byte lane SHALL be alu_result[1:0].
REQ-017 A half access with addr[0]=1, or a word access with addr[1:0]!=0, SHALL be misaligned: no memory access, no stall.
REQ-018 A misaligned access SHALL produce a one-cycle MEM/WB entry with misalign=1 and mem_control_wb=00.
REQ-019 The FSM SHALL have states IDLE and WAIT plus a 3-bit wait counter.
REQ-020 In IDLE, an aligned memread or memwrite with WAIT_CYC>0 SHALL enter WAIT, load the counter with WAIT_CYC-1, and assert stall combinationally in that same cycle.
REQ-021 stall SHALL be high in the request cycle and in every WAIT cycle except the last; the total access is WAIT_CYC+1 cycles and stall is high for WAIT_CYC cycles.
REQ-022 Upstream SHALL hold all inputs stable while stall=1; the block does not capture them.
REQ-023 On every stalled cycle, MEM/WB SHALL load a bubble: mem_control_wb=00, with the other outputs unchanged.
REQ-024 The access SHALL complete on the edge ending the last non-stalled cycle; at that edge a store writes and a load result is latched; the FSM then returns to IDLE.
REQ-025 Byte stores SHALL write only the addressed lane, half stores lanes {1:0} or {3:2}, and word stores all four lanes, using the low bits of wdata.
REQ-026 Loads SHALL select the addressed byte or half and extend it to DATA_W according to mem_unsigned.
REQ-027 When memread and memwrite are both 1, the store SHALL take effect and mem_Read_data SHALL load 0.
REQ-028 When WAIT_CYC=0, accesses SHALL complete in one cycle with stall never asserted.
REQ-029 Non-memory cycles SHALL latch wb_ctl_in, alu_result and write_reg_in, with mem_Read_data=0 and misalign=0.
REQ-030 A back-to-back access presented in the cycle after completion SHALL start a new WAIT sequence with no idle gap.

Reset
REQ-031 rst_n low SHALL immediately force FSM=IDLE, counter=0, stall=0, misalign=0, and all MEM/WB outputs to 0.
REQ-032 Reset during WAIT SHALL abandon the access: a pending store does not write memory.
REQ-033 Memory contents SHALL be unaffected by rst_n; in simulation they SHALL initialise to 0.

Verification
REQ-034 WAIT_CYC=2: store word 0xDEADBEEF to addr 0x10 -> stall high for 2 cycles, mem_control_wb=00 on both, write on the 3rd edge; a later word load from 0x10 returns 0xDEADBEEF.
REQ-035 Byte load from 0x13 with mem_unsigned=0 and mem_unsigned=1 -> 0xFFFFFFDE and 0x000000DE respectively.
REQ-036 Half store with addr=0x21 -> misalign=1 for one cycle, mem_control_wb=00, stall=0, memory unchanged.
REQ-037 Assert rst_n=0 during the 1st WAIT cycle of a store to 0x40 -> outputs are 0 immediately; a later load from 0x40 returns the old value.
REQ-038 branch_ne=1, zero=0, npc_in=0x100 -> PCSrc=1 and branch_addr=0x100 in the same cycle; with zero=1 -> PCSrc=0.
REQ-039 DEPTH=16: word store to 0x40 -> read back at 0x00 (wrap-around).

Source files
------------

// File: rtl/mem_stage_pipe_if.sv
// EX/MEM -> MEM/WB bundle for the memory stage: request side inputs,
// branch resolution outputs, stall/misalign status and the MEM/WB register.
interface mem_stage_pipe_if #(
  parameter int DATA_W = 32
);
  logic [1:0]        wb_ctl_in;
  logic              branch;
  logic              branch_ne;
  logic              memread;
  logic              memwrite;
  logic [1:0]        mem_size;
  logic              mem_unsigned;
  logic [DATA_W-1:0] npc_in;
  logic [DATA_W-1:0] alu_result;
  logic [DATA_W-1:0] wdata;
  logic              zero;
  logic [4:0]        write_reg_in;

  logic              PCSrc;
  logic [DATA_W-1:0] branch_addr;
  logic              stall;
  logic              misalign;
  logic [1:0]        mem_control_wb;
  logic [DATA_W-1:0] mem_Read_data;
  logic [DATA_W-1:0] mem_ALU_result;
  logic [4:0]        mem_Write_reg;

  modport master (
    output wb_ctl_in, branch, branch_ne, memread, memwrite, mem_size,
           mem_unsigned, npc_in, alu_result, wdata, zero, write_reg_in,
    input  PCSrc, branch_addr, stall, misalign, mem_control_wb,
           mem_Read_data, mem_ALU_result, mem_Write_reg
  );

  modport slave (
    input  wb_ctl_in, branch, branch_ne, memread, memwrite, mem_size,
           mem_unsigned, npc_in, alu_result, wdata, zero, write_reg_in,
    output PCSrc, branch_addr, stall, misalign, mem_control_wb,
           mem_Read_data, mem_ALU_result, mem_Write_reg
  );
endinterface

// File: rtl/mem_stage_pipe.sv
// Pipeline MEM stage: branch resolution, wait-stated data memory with
// byte/half/word access, misalignment detection and the MEM/WB register.
module mem_stage_pipe #(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 256,
  parameter int WAIT_CYC = 2
) (
  input logic             clk,
  input logic             rst_n,
  mem_stage_pipe_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [2:0]        CNT_LOAD = (WAIT_CYC > 0) ? 3'(WAIT_CYC - 1) : 3'd0;
  localparam logic [DATA_W-1:0] BYTE_M   = DATA_W'(32'h0000_00FF);
  localparam logic [DATA_W-1:0] HALF_LO  = DATA_W'(32'h0000_FFFF);
  localparam logic [DATA_W-1:0] HALF_HI  = DATA_W'(32'hFFFF_0000);

  generate
    if (DATA_W != 32) begin : g_bad_width
      $error("mem_stage_pipe: DATA_W must be 32");
    end
    if (DEPTH < 16 || DEPTH > 4096 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("mem_stage_pipe: DEPTH must be a power of two in 16..4096");
    end
    if (WAIT_CYC < 0 || WAIT_CYC > 7) begin : g_bad_wait
      $error("mem_stage_pipe: WAIT_CYC must be in 0..7");
    end
  endgenerate

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [2:0]        r_cnt;
  logic [2:0]        w_cnt_nxt;

  logic [DATA_W-1:0] r_mem [DEPTH];

  logic [1:0]        r_ctl_wb;
  logic [DATA_W-1:0] r_rdata;
  logic [DATA_W-1:0] r_alu;
  logic [4:0]        r_wreg;
  logic              r_misal;

  logic [1:0]        w_lane;
  logic [AW-1:0]     w_idx;
  logic              w_is_byte;
  logic              w_is_half;
  logic              w_is_word;
  logic              w_mem_req;
  logic              w_misal;
  logic              w_access;
  logic              w_stall;
  logic              w_done;
  logic              w_mem_we;

  logic [DATA_W-1:0] w_rd_word;
  logic [DATA_W-1:0] w_rd_shift;
  logic [15:0]       w_rd_half;
  logic [DATA_W-1:0] w_load_ext;
  logic [DATA_W-1:0] w_wmask;
  logic [DATA_W-1:0] w_wlane;
  logic [DATA_W-1:0] w_wr_word;

  // Branch resolution is purely combinational and independent of the FSM.
  assign bus.PCSrc       = (bus.branch & bus.zero) | (bus.branch_ne & ~bus.zero);
  assign bus.branch_addr = bus.npc_in;

  // Address decode and alignment classification.
  assign w_lane    = bus.alu_result[1:0];
  assign w_idx     = bus.alu_result[AW+1:2];
  assign w_is_byte = (bus.mem_size == 2'b00);
  assign w_is_half = (bus.mem_size == 2'b01);
  assign w_is_word = bus.mem_size[1];
  assign w_mem_req = bus.memread | bus.memwrite;
  assign w_misal   = w_mem_req & ((w_is_half & w_lane[0]) | (w_is_word & (w_lane != 2'b00)));
  assign w_access  = w_mem_req & ~w_misal;

  // FSM state and wait counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state: an aligned request opens a wait window, the counter drains to zero.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_access && (WAIT_CYC != 0)) begin
          w_state_nxt = S_WAIT;
          w_cnt_nxt   = CNT_LOAD;
        end
      end
      S_WAIT: begin
        if (r_cnt == 3'd0) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt - 3'd1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // FSM outputs: stall covers the request cycle and all but the last wait
  // cycle; done marks the cycle whose closing edge commits the access.
  // Gated by rst_n so stall drops and no store commits while reset is held.
  always_comb begin
    w_stall = 1'b0;
    w_done  = 1'b0;
    if (rst_n) begin
      case (r_state)
        S_IDLE: begin
          if (w_access) begin
            if (WAIT_CYC == 0) begin
              w_done = 1'b1;
            end else begin
              w_stall = 1'b1;
            end
          end
        end
        S_WAIT: begin
          if (r_cnt == 3'd0) begin
            w_done = 1'b1;
          end else begin
            w_stall = 1'b1;
          end
        end
        default: begin
          w_stall = 1'b0;
          w_done  = 1'b0;
        end
      endcase
    end
  end

  assign bus.stall = w_stall;
  assign w_mem_we  = w_done & bus.memwrite;

  // Load path: pick the addressed lane and extend to full width.
  always_comb begin
    w_rd_word  = r_mem[w_idx];
    w_rd_shift = w_rd_word >> {w_lane, 3'b000};
    w_rd_half  = w_lane[1] ? w_rd_word[31:16] : w_rd_word[15:0];
    if (w_is_byte) begin
      w_load_ext = {{(DATA_W-8){~bus.mem_unsigned & w_rd_shift[7]}}, w_rd_shift[7:0]};
    end else if (w_is_half) begin
      w_load_ext = {{(DATA_W-16){~bus.mem_unsigned & w_rd_half[15]}}, w_rd_half};
    end else begin
      w_load_ext = w_rd_word;
    end
  end

  // Store path: replicate the low store bits across lanes, then merge under a lane mask.
  always_comb begin
    if (w_is_byte) begin
      w_wmask = BYTE_M << {w_lane, 3'b000};
      w_wlane = {4{bus.wdata[7:0]}};
    end else if (w_is_half) begin
      w_wmask = w_lane[1] ? HALF_HI : HALF_LO;
      w_wlane = {2{bus.wdata[15:0]}};
    end else begin
      w_wmask = '1;
      w_wlane = bus.wdata;
    end
    w_wr_word = (w_rd_word & ~w_wmask) | (w_wlane & w_wmask);
  end

  // Data memory write; contents are deliberately outside the reset domain.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_idx] <= w_wr_word;
    end
  end

  // MEM/WB register: bubble while stalled, fault entry on misalignment,
  // otherwise latch the stage result (load data only for a pure load).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ctl_wb <= '0;
      r_rdata  <= '0;
      r_alu    <= '0;
      r_wreg   <= '0;
      r_misal  <= 1'b0;
    end else if (w_stall) begin
      r_ctl_wb <= '0;
      r_misal  <= 1'b0;
    end else begin
      r_alu  <= bus.alu_result;
      r_wreg <= bus.write_reg_in;
      if (w_misal && (r_state == S_IDLE)) begin
        r_ctl_wb <= '0;
        r_rdata  <= '0;
        r_misal  <= 1'b1;
      end else begin
        r_ctl_wb <= bus.wb_ctl_in;
        r_rdata  <= (w_done && bus.memread && !bus.memwrite) ? w_load_ext : '0;
        r_misal  <= 1'b0;
      end
    end
  end

  assign bus.mem_control_wb = r_ctl_wb;
  assign bus.mem_Read_data  = r_rdata;
  assign bus.mem_ALU_result = r_alu;
  assign bus.mem_Write_reg  = r_wreg;
  assign bus.misalign       = r_misal;

endmodule
